// File: rtl/gpio_irq_regs_if.sv
// Local CSR bus between the CPU decoder (master) and a register block (slave).
// Separate write and read channels; writes always accepted, reads return one cycle later.
interface gpio_irq_regs_if;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output waddr, wdata, wen, wstrb, raddr, ren,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  waddr, wdata, wen, wstrb, raddr, ren,
        output wready, rdata, rvalid
    );
endinterface

// File: rtl/gpio_irq_regs.sv
// GPIO register block: per-pin direction, atomic set/clear outputs, synchronised
// inputs and maskable edge/level interrupts behind the local CSR bus.

module gpio_pin_irq (
    input  logic s,
    input  logic p,
    input  logic dir,
    input  logic irq_type,
    input  logic pol,
    input  logic primed,
    output logic det
);
    logic edge_hit;
    logic level_hit;

    assign edge_hit  = pol ? (s & ~p) : (~s & p);
    assign level_hit = pol ? s : ~s;
    assign det       = primed & ~dir & (irq_type ? edge_hit : level_hit);
endmodule

module gpio_irq_regs #(
    parameter int N_PINS      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq,
    gpio_irq_regs_if.slave    bus
);
    localparam logic [31:0] A_DATA_OUT = 32'h00;
    localparam logic [31:0] A_DATA_IN  = 32'h04;
    localparam logic [31:0] A_DIR      = 32'h08;
    localparam logic [31:0] A_OUT_SET  = 32'h0C;
    localparam logic [31:0] A_OUT_CLR  = 32'h10;
    localparam logic [31:0] A_IRQ_EN   = 32'h14;
    localparam logic [31:0] A_IRQ_TYPE = 32'h18;
    localparam logic [31:0] A_IRQ_POL  = 32'h1C;
    localparam logic [31:0] A_IRQ_STAT = 32'h20;
    localparam logic [2:0]  PRIME_MAX  = 3'(SYNC_STAGES + 1);

    logic [N_PINS-1:0] data_out, dir, irq_en, irq_type, irq_pol, irq_status;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;
    logic [N_PINS-1:0] s, p, det, wm, wd, w1c;
    logic [2:0]        prime_cnt;
    logic              primed;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign primed       = (prime_cnt == PRIME_MAX);
    assign wd           = bus.wdata[N_PINS-1:0];
    assign unused_wdata = ^bus.wdata;
    assign bus.wready   = 1'b1;

    // Byte-lane strobes expanded to a per-pin write mask.
    always_comb begin
        wm = '0;
        for (int i = 0; i < N_PINS; i++) wm[i] = bus.wstrb[i/8];
    end

    assign w1c = (bus.wen && bus.waddr == A_IRQ_STAT) ? (wd & wm) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            p         <= '0;
            prime_cnt <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            p <= s;
            if (!primed) prime_cnt <= prime_cnt + 3'd1;
        end
    end

    for (genvar g = 0; g < N_PINS; g++) begin : g_pin
        gpio_pin_irq u_pin (
            .s        (s[g]),
            .p        (p[g]),
            .dir      (dir[g]),
            .irq_type (irq_type[g]),
            .pol      (irq_pol[g]),
            .primed   (primed),
            .det      (det[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            dir        <= '0;
            irq_en     <= '0;
            irq_type   <= '0;
            irq_pol    <= '0;
            irq_status <= '0;
        end else begin
            if (bus.wen) begin
                case (bus.waddr)
                    A_DATA_OUT: data_out <= (data_out & ~wm) | (wd & wm);
                    A_OUT_SET:  data_out <= data_out | (wd & wm);
                    A_OUT_CLR:  data_out <= data_out & ~(wd & wm);
                    A_DIR:      dir      <= (dir & ~wm) | (wd & wm);
                    A_IRQ_EN:   irq_en   <= (irq_en & ~wm) | (wd & wm);
                    A_IRQ_TYPE: irq_type <= (irq_type & ~wm) | (wd & wm);
                    A_IRQ_POL:  irq_pol  <= (irq_pol & ~wm) | (wd & wm);
                    default: ;
                endcase
            end
            // OR-ing det after the clear makes a same-cycle hardware set win.
            irq_status <= (irq_status & ~w1c) | det;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.raddr)
            A_DATA_OUT: rd_mux = 32'(data_out);
            A_DATA_IN:  rd_mux = 32'(s);
            A_DIR:      rd_mux = 32'(dir);
            A_IRQ_EN:   rd_mux = 32'(irq_en);
            A_IRQ_TYPE: rd_mux = 32'(irq_type);
            A_IRQ_POL:  rd_mux = 32'(irq_pol);
            A_IRQ_STAT: rd_mux = 32'(irq_status);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.ren;
            bus.rdata  <= bus.ren ? rd_mux : '0;
        end
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(irq_status & irq_en);
endmodule
